// File: rtl/lis3dh_spi_responder_if.sv
// SPI pins plus register-file port of the LIS3DH responder.
// master: SPI controller / register file side; slave: the responder.
interface lis3dh_spi_responder_if;
    logic       cs;
    logic       spc;
    logic       sdi;
    logic       sdo;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;

    modport master (
        output cs, spc, sdi, reg_rdata,
        input  sdo, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );

    modport slave (
        input  cs, spc, sdi, reg_rdata,
        output sdo, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );
endinterface

// File: rtl/lis3dh_spi_responder.sv
// LIS3DH-style SPI mode-3 responder bridging to a 6-bit register-file port.
// Define LIS3DH_SPI_AUTOINC_EN to honour the MS bit (per-byte address increment).
module lis3dh_spi_responder (
    input  logic                  clk,
    input  logic                  reset_n,
    lis3dh_spi_responder_if.slave bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CMD     = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] RD_LOAD = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;

    logic [2:0] state;
    logic       cs_p0, cs_p1, cs_p2;
    logic       spc_p0, spc_p1, spc_p2;
    logic       sdi_p0, sdi_p1;
    logic       spc_rise, spc_fall, cs_fall;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic [6:0] rx_sr;
    logic [7:0] rx_byte;
    logic [7:0] tx_sr;
    logic       tx_shift;
    logic       first_fall;
    logic       ms_q;
    logic       inc_en;

    function automatic logic [5:0] addr_next(input logic [5:0] a);
        return a + 6'd1;
    endfunction

`ifdef LIS3DH_SPI_AUTOINC_EN
    assign inc_en = ms_q;
`else
    assign inc_en = ms_q & 1'b0;
`endif

    // p0/p1: two-flop synchronizers; p2: edge history for cs and spc
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_p0  <= 1'b1;
            cs_p1  <= 1'b1;
            cs_p2  <= 1'b1;
            spc_p0 <= 1'b1;
            spc_p1 <= 1'b1;
            spc_p2 <= 1'b1;
        end else begin
            cs_p0  <= bus.cs;
            cs_p1  <= cs_p0;
            cs_p2  <= cs_p1;
            spc_p0 <= bus.spc;
            spc_p1 <= spc_p0;
            spc_p2 <= spc_p1;
        end
    end

    always_ff @(posedge clk) begin
        sdi_p0 <= bus.sdi;
        sdi_p1 <= sdi_p0;
    end

    assign spc_rise  = spc_p1 & ~spc_p2;
    assign spc_fall  = ~spc_p1 & spc_p2;
    assign cs_fall   = ~cs_p1 & cs_p2;
    assign rx_byte   = {rx_sr, sdi_p1};
    assign byte_done = spc_rise && (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (spc_rise)
            rx_sr <= rx_byte[6:0];
    end

    // The load already presents bit7, so the first fall after a load must not shift.
    assign tx_shift = (state == RD_DATA) && spc_fall && !first_fall;

    always_ff @(posedge clk) begin
        if (state == RD_LOAD)
            tx_sr <= bus.reg_rdata;
        else if (tx_shift)
            tx_sr <= {tx_sr[6:0], 1'b1};
    end

    assign bus.sdo  = ((state == RD_DATA) || (state == RD_LOAD)) ? tx_sr[7] : 1'b1;
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            ms_q          <= 1'b0;
            first_fall    <= 1'b0;
            bus.reg_addr  <= 6'd0;
            bus.reg_wdata <= 8'd0;
            bus.reg_wr    <= 1'b0;
            bus.reg_rd    <= 1'b0;
        end else begin
            bus.reg_wr <= 1'b0;
            bus.reg_rd <= 1'b0;
            if (bus.reg_wr && inc_en)
                bus.reg_addr <= addr_next(bus.reg_addr);

            if ((state != IDLE) && cs_p1) begin
                state   <= IDLE;
                bit_cnt <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= CMD;
                            bit_cnt <= 3'd0;
                        end
                    end
                    CMD: begin
                        // reg_rd is registered, so RD_LOAD starts the cycle reg_rdata is valid
                        if (bus.reg_rd) begin
                            state <= RD_LOAD;
                        end else if (spc_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (byte_done) begin
                                ms_q         <= rx_byte[6];
                                bus.reg_addr <= rx_byte[5:0];
                                if (rx_byte[7])
                                    bus.reg_rd <= 1'b1;
                                else
                                    state <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (spc_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (byte_done) begin
                                bus.reg_wr    <= 1'b1;
                                bus.reg_wdata <= rx_byte;
                            end
                        end
                    end
                    RD_LOAD: begin
                        state      <= RD_DATA;
                        first_fall <= 1'b1;
                    end
                    RD_DATA: begin
                        if (bus.reg_rd) begin
                            state <= RD_LOAD;
                        end else begin
                            if (spc_fall)
                                first_fall <= 1'b0;
                            if (spc_rise) begin
                                bit_cnt <= bit_cnt + 3'd1;
                                if (byte_done) begin
                                    bus.reg_rd <= 1'b1;
                                    if (inc_en)
                                        bus.reg_addr <= addr_next(bus.reg_addr);
                                end
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        bit_cnt <= 3'd0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lis3dh_spi_responder.sv
// Scoreboard bench for lis3dh_spi_responder: SPI master + register-file model,
// expectations derived per transaction from the command byte.
module tb_lis3dh_spi_responder;
    localparam int HP = 6;
`ifdef LIS3DH_SPI_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    lis3dh_spi_responder_if bus ();

    lis3dh_spi_responder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [13:0] exp_wr[$];
    logic [5:0]  exp_rd[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  mem[64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: unexpected output 0x%0h, nothing expected at %0t", name, act, $time);
    endtask

    // Register file: data valid exactly the cycle after reg_rd, garbage otherwise.
    logic       rd_pend = 1'b0;
    logic [5:0] rd_a = 6'd0;
    always @(negedge clk) begin
        rd_pend = bus.reg_rd;
        rd_a    = bus.reg_addr;
    end
    always @(posedge clk) begin
        #1;
        bus.reg_rdata = rd_pend ? mem[rd_a] : 8'($urandom);
    end

    // Register-port monitor
    always @(negedge clk) begin
        if (bus.reg_wr || bus.reg_rd)
            check("wr_rd_exclusive", 32'(bus.reg_wr & bus.reg_rd), 32'd0);
        if (bus.reg_wr) begin
            if (exp_wr.size() == 0) unexpected("reg_wr", {bus.reg_addr, bus.reg_wdata});
            else check("reg_wr addr/data", {bus.reg_addr, bus.reg_wdata}, exp_wr.pop_front());
        end
        if (bus.reg_rd) begin
            if (exp_rd.size() == 0) unexpected("reg_rd", bus.reg_addr);
            else check("reg_rd addr", bus.reg_addr, exp_rd.pop_front());
        end
    end

    // SPI master sampling: sdo captured on spc rise, whole read bytes scored
    int         mcnt = 0;
    logic [7:0] mcmd = 8'd0;
    logic [7:0] mbyte = 8'd0;
    always @(posedge bus.spc or posedge bus.cs) begin
        if (bus.cs) begin
            mcnt = 0;
        end else begin
            if (mcnt < 8) begin
                mcmd = {mcmd[6:0], bus.sdi};
            end else if (mcmd[7]) begin
                mbyte = {mbyte[6:0], bus.sdo};
                if (mcnt % 8 == 7) begin
                    if (exp_rx.size() == 0) unexpected("sdo_byte", mbyte);
                    else check("sdo_byte", mbyte, exp_rx.pop_front());
                end
            end
            mcnt++;
        end
    end

    task automatic send_bits(input logic [7:0] b, input int nb);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            bus.spc = 1'b0;
            bus.sdi = b[7-i];
            repeat (HP) @(negedge clk);
            bus.spc = 1'b1;
            repeat (HP - 1) @(negedge clk);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " sdo"},       bus.sdo,       32'd1);
        check({tag, " reg_addr"},  bus.reg_addr,  32'd0);
        check({tag, " reg_wdata"}, bus.reg_wdata, 32'd0);
        check({tag, " reg_wr"},    bus.reg_wr,    32'd0);
        check({tag, " reg_rd"},    bus.reg_rd,    32'd0);
        check({tag, " busy"},      bus.busy,      32'd0);
    endtask

    task automatic end_cs();
        repeat (HP) @(negedge clk);
        bus.cs = 1'b1;
        repeat (8) @(negedge clk);
        check("busy_after_cs", bus.busy, 32'd0);
        check("sdo_after_cs", bus.sdo, 32'd1);
        check("wr_outstanding", exp_wr.size(), 32'd0);
        check("rd_outstanding", exp_rd.size(), 32'd0);
        check("rx_outstanding", exp_rx.size(), 32'd0);
    endtask

    // Model: byte k of a burst targets addr+k (mod 64) when incrementing, else addr.
    // A read of n bytes issues n+1 reads (the last is the prefetch).
    task automatic run_txn(input logic [7:0] cmd, input int nbytes, input int tail,
                           input logic [31:0] wd, input bit finish);
        int a;
        int ak;
        bit inc;
        a   = int'(cmd[5:0]);
        inc = AUTOINC && cmd[6];
        for (int k = 0; k <= nbytes; k++) begin
            ak = inc ? (a + k) % 64 : a;
            if (cmd[7]) begin
                exp_rd.push_back(6'(ak));
                if (k < nbytes) exp_rx.push_back(mem[ak]);
            end else if (k < nbytes) begin
                exp_wr.push_back({6'(ak), wd[8*k +: 8]});
            end
        end
        @(negedge clk);
        bus.cs = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(cmd, 8);
        check("busy_in_txn", bus.busy, 32'd1);
        for (int k = 0; k < nbytes; k++)
            send_bits(cmd[7] ? 8'($urandom) : wd[8*k +: 8], 8);
        if (tail > 0) send_bits(8'($urandom), tail);
        if (finish) end_cs();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        reset_n = 1'b0;
        bus.cs  = 1'b1;
        bus.spc = 1'b1;
        bus.sdi = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i + 16);
        mem[6'h0F] = 8'h33;
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        run_txn(8'h20, 1, 0, 32'h57, 1);
        run_txn(8'h8F, 1, 0, 32'h0, 1);
        run_txn(8'h7F, 2, 0, 32'hB2A1, 1);
        run_txn(8'hE8, 3, 0, 32'h0, 1);
        run_txn(8'h05, 0, 5, 32'h0, 1);
        run_txn(8'h05, 1, 0, 32'hC3, 1);

        // reset in the middle of a burst read, with cs still low
        run_txn(8'hE8, 1, 3, 32'h0, 0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset("reset_mid_read");
        bus.cs  = 1'b1;
        bus.spc = 1'b1;
        repeat (3) @(negedge clk);
        exp_wr.delete();
        exp_rd.delete();
        exp_rx.delete();
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        run_txn(8'hE8, 3, 0, 32'h0, 1);

        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 24; t++)
            run_txn(8'($urandom), int'($urandom_range(1, 4)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0,
                    $urandom, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
